// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue controller: the ALU datapath width,
//   the opcode encodings understood by the gate-level ALU decoder and the
//   issue FSM state type.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_RSP
    } state_t;

endpackage

// File: rtl/alu_settle_cnt.sv
// ---------------------------------------------------------------------------
// alu_settle_cnt
//   4-bit loadable down-counter that measures how long the ALU inputs have
//   been held stable. It counts down to zero and stays there.
//
// Ports:
//   clk       clock
//   rst       synchronous reset, active-high (counter -> 0)
//   load      load load_val this cycle (has priority over counting)
//   load_val  value to load
//   zero      counter currently equals zero
// ---------------------------------------------------------------------------
module alu_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Command front-end for the 32-bit gate-level ALU. A command is accepted
//   over a valid/ready handshake, the ALU inputs are registered and held for
//   SETTLE_CYCLES cycles, then the ALU result is sampled. Wide (64-bit)
//   commands run a second pass on the upper halves, chaining the carry for
//   ADD. The result is returned over a valid/ready response channel.
//
// Parameters:
//   SETTLE_CYCLES  cycles the ALU inputs are held before sampling (1..15)
//   OP_W           opcode width (fixed at 3, matches the ALU decoder)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_wide            opcode, 64-bit request
//   cmd_a, cmd_b, cmd_ci        operands and carry-in
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_co, rsp_err   result, final carry (ADD only), illegal wide
//   alu_in1, alu_in2, alu_ci,
//   alu_a                       registered drive to the ALU
//   alu_out, alu_co             ALU FinalOut and CO
//
// Optional build macro ALU_ISSUE_CNT_EN adds:
//   op_count[31:0]   response handshakes, wrapping
//   err_count[15:0]  response handshakes with rsp_err set, saturating
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int OP_W          = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_W-1:0]      cmd_op,
    input  logic                 cmd_wide,
    input  logic [2*ALU_W-1:0]   cmd_a,
    input  logic [2*ALU_W-1:0]   cmd_b,
    input  logic                 cmd_ci,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*ALU_W-1:0]   rsp_data,
    output logic                 rsp_co,
    output logic                 rsp_err,
    output logic [ALU_W-1:0]     alu_in1,
    output logic [ALU_W-1:0]     alu_in2,
    output logic                 alu_ci,
    output logic [OP_W-1:0]      alu_a,
    input  logic [ALU_W-1:0]     alu_out,
    input  logic                 alu_co
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [31:0]          op_count,
    output logic [15:0]          err_count
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t            state, state_nxt;
    logic              cnt_zero;
    logic              cnt_load;
    logic              rsp_fire;
    logic              is_add;

    // Latched command fields needed after the handshake.
    logic [OP_W-1:0]   op_q;
    logic              wide_q;   // wide request that really runs two passes
    logic              err_q;    // wide request for an op that cannot span 64 bits
    logic [ALU_W-1:0]  a_hi_q;
    logic [ALU_W-1:0]  b_hi_q;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RSP);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign is_add    = (op_q == OP_ADD);

    // Reload on accept and again when the low pass of a wide op hands over
    // to the high pass.
    assign cnt_load  = (cmd_ready && cmd_valid) ||
                       ((state == ST_LO) && cnt_zero && wide_q);

    alu_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so that every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_nxt = ST_LO;
            ST_LO:   if (cnt_zero)  state_nxt = wide_q ? ST_HI : ST_RSP;
            ST_HI:   if (cnt_zero)  state_nxt = ST_RSP;
            ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_ci   <= 1'b0;
            alu_a    <= '0;
            rsp_data <= '0;
            rsp_co   <= 1'b0;
            rsp_err  <= 1'b0;
            op_q     <= '0;
            wide_q   <= 1'b0;
            err_q    <= 1'b0;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        alu_in1 <= cmd_a[ALU_W-1:0];
                        alu_in2 <= cmd_b[ALU_W-1:0];
                        alu_a   <= cmd_op;
                        alu_ci  <= (cmd_op == OP_ADD) ? cmd_ci : 1'b0;
                        op_q    <= cmd_op;
                        wide_q  <= cmd_wide && (cmd_op < OP_SRL);
                        err_q   <= cmd_wide && (cmd_op >= OP_SRL);
                        a_hi_q  <= cmd_a[2*ALU_W-1:ALU_W];
                        b_hi_q  <= cmd_b[2*ALU_W-1:ALU_W];
                    end
                end
                ST_LO: begin
                    if (cnt_zero) begin
                        rsp_data <= {{ALU_W{1'b0}}, alu_out};
                        rsp_co   <= is_add && alu_co;
                        rsp_err  <= err_q;
                        if (wide_q) begin
                            // High pass: same opcode, carry chained for ADD.
                            alu_in1 <= a_hi_q;
                            alu_in2 <= b_hi_q;
                            alu_ci  <= is_add && alu_co;
                        end else begin
                            alu_in1 <= '0;
                            alu_in2 <= '0;
                            alu_ci  <= 1'b0;
                            alu_a   <= '0;
                        end
                    end
                end
                ST_HI: begin
                    if (cnt_zero) begin
                        rsp_data[2*ALU_W-1:ALU_W] <= alu_out;
                        rsp_co  <= is_add && alu_co;
                        alu_in1 <= '0;
                        alu_in2 <= '0;
                        alu_ci  <= 1'b0;
                        alu_a   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count  <= 32'd0;
            err_count <= 16'd0;
        end else if (rsp_fire) begin
            op_count <= op_count + 32'd1;
            if (rsp_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Self-checking bench for alu_issue_ctrl. A behavioural ALU closes the loop
//   on the ALU-side ports. Expected responses come from a 64-bit reference
//   model, are queued when a command is accepted and compared when the
//   response appears. A second instance with SETTLE_CYCLES=3 exercises reset
//   during the high pass.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int S  = 1;
    localparam int S3 = 3;

    typedef struct {
        logic [63:0] data;
        logic        co;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (SETTLE_CYCLES = 1)
    logic        rst, cmd_valid, cmd_ready, cmd_wide, cmd_ci;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_a, cmd_b;
    logic        rsp_valid, rsp_ready, rsp_co, rsp_err;
    logic [63:0] rsp_data;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_ci, alu_co;
    logic [2:0]  alu_a;

    // Reset-test instance (SETTLE_CYCLES = 3)
    logic        r3_rst, r3_cmd_valid, r3_cmd_ready, r3_cmd_wide, r3_cmd_ci;
    logic [2:0]  r3_cmd_op;
    logic [63:0] r3_cmd_a, r3_cmd_b;
    logic        r3_rsp_valid, r3_rsp_ready, r3_rsp_co, r3_rsp_err;
    logic [63:0] r3_rsp_data;
    logic [31:0] r3_alu_in1, r3_alu_in2, r3_alu_out;
    logic        r3_alu_ci, r3_alu_co;
    logic [2:0]  r3_alu_a;

`ifdef ALU_ISSUE_CNT_EN
    logic [31:0] op_count, r3_op_count;
    logic [15:0] err_count, r3_err_count;
`endif

    alu_issue_ctrl #(.SETTLE_CYCLES(S), .OP_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wide(cmd_wide), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ci(cmd_ci),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_co(rsp_co), .rsp_err(rsp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ci(alu_ci), .alu_a(alu_a),
        .alu_out(alu_out), .alu_co(alu_co)
`ifdef ALU_ISSUE_CNT_EN
        , .op_count(op_count), .err_count(err_count)
`endif
    );

    alu_issue_ctrl #(.SETTLE_CYCLES(S3), .OP_W(3)) dut3 (
        .clk(clk), .rst(r3_rst),
        .cmd_valid(r3_cmd_valid), .cmd_ready(r3_cmd_ready), .cmd_op(r3_cmd_op),
        .cmd_wide(r3_cmd_wide), .cmd_a(r3_cmd_a), .cmd_b(r3_cmd_b), .cmd_ci(r3_cmd_ci),
        .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_data(r3_rsp_data),
        .rsp_co(r3_rsp_co), .rsp_err(r3_rsp_err),
        .alu_in1(r3_alu_in1), .alu_in2(r3_alu_in2), .alu_ci(r3_alu_ci), .alu_a(r3_alu_a),
        .alu_out(r3_alu_out), .alu_co(r3_alu_co)
`ifdef ALU_ISSUE_CNT_EN
        , .op_count(r3_op_count), .err_count(r3_err_count)
`endif
    );

    // Behavioural 32-bit ALU. CO is garbage (parity of In1) for non-ADD ops
    // so the controller's masking of rsp_co is observable.
    function automatic logic [32:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] op, input logic c);
        case (op)
            3'd0:    return {^x, x & y};
            3'd1:    return {^x, x | y};
            3'd2:    return {^x, x ^ y};
            3'd3:    return {^x, ~x};
            3'd4:    return {1'b0, x} + {1'b0, y} + {32'd0, c};
            3'd5:    return {^x, x >> y[4:0]};
            3'd6:    return {^x, x << y[4:0]};
            default: return {^x, x ^ 32'hDEADBEEF};
        endcase
    endfunction

    assign {alu_co, alu_out}       = alu_fn(alu_in1, alu_in2, alu_a, alu_ci);
    assign {r3_alu_co, r3_alu_out} = alu_fn(r3_alu_in1, r3_alu_in2, r3_alu_a, r3_alu_ci);

    // Reference model of the whole command, computed on full 64-bit values.
    function automatic exp_t model(input logic [2:0] op, input logic wide,
                                   input logic [63:0] a, input logic [63:0] b, input logic ci);
        exp_t        e;
        logic [64:0] sum;
        logic [32:0] s32;
        logic [31:0] lo;
        e.co  = 1'b0;
        e.err = wide && (op >= 3'd5);
        if (wide && (op < 3'd5)) begin
            e.lat = 2 * S;
            case (op)
                3'd0: e.data = a & b;
                3'd1: e.data = a | b;
                3'd2: e.data = a ^ b;
                3'd3: e.data = ~a;
                default: begin
                    sum    = {1'b0, a} + {1'b0, b} + {64'd0, ci};
                    e.data = sum[63:0];
                    e.co   = sum[64];
                end
            endcase
        end else begin
            e.lat = S;
            lo    = '0;
            case (op)
                3'd0: lo = a[31:0] & b[31:0];
                3'd1: lo = a[31:0] | b[31:0];
                3'd2: lo = a[31:0] ^ b[31:0];
                3'd3: lo = ~a[31:0];
                3'd4: begin
                    s32  = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, ci};
                    lo   = s32[31:0];
                    e.co = s32[32];
                end
                3'd5: lo = a[31:0] >> b[4:0];
                3'd6: lo = a[31:0] << b[4:0];
                default: lo = a[31:0] ^ 32'hDEADBEEF;
            endcase
            e.data = {32'd0, lo};
        end
        return e;
    endfunction

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t_hs = 0;
    int   n_rsp_hs = 0;
    int   n_err_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic issue(input logic [2:0] op, input logic wide,
                         input logic [63:0] a, input logic [63:0] b, input logic ci);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_wide = wide;
        cmd_a = a; cmd_b = b; cmd_ci = ci;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout cmd_ready=%0b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t_hs = cyc;
        sb.push_back(model(op, wide, a, b, ci));
        // Scramble the command bus; it must be ignored outside IDLE.
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_wide  = 1'($urandom);
        cmd_a     = {$urandom, $urandom};
        cmd_b     = {$urandom, $urandom};
        cmd_ci    = 1'($urandom);
    endtask

    task automatic get_rsp(input int hold, input string name);
        exp_t e;
        int   n;
        rsp_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!rsp_valid) begin
            n_bad++;
            $display("FAIL %s rsp_timeout rsp_valid=%0b required 1", name, rsp_valid);
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s unexpected_rsp queue_size=0 required >0", name);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if ((cyc - t_hs) != e.lat) begin
            n_bad++;
            $display("FAIL %s latency got=%0d required=%0d", name, cyc - t_hs, e.lat);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== e.data) begin
                n_bad++;
                $display("FAIL %s hold%0d valid=%0b ready=%0b data=%h required 1/0/%h",
                         name, i, rsp_valid, cmd_ready, rsp_data, e.data);
            end
        end
        n_cmp++;
        if (rsp_data !== e.data) begin
            n_bad++;
            $display("FAIL %s data got=%h required=%h", name, rsp_data, e.data);
        end
        n_cmp++;
        if (rsp_co !== e.co) begin
            n_bad++;
            $display("FAIL %s co got=%0b required=%0b", name, rsp_co, e.co);
        end
        n_cmp++;
        if (rsp_err !== e.err) begin
            n_bad++;
            $display("FAIL %s err got=%0b required=%0b", name, rsp_err, e.err);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_rsp_hs++;
        if (e.err) n_err_hs++;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s post_hs valid=%0b ready=%0b required 0/1", name, rsp_valid, cmd_ready);
        end
    endtask

    // Checks that the high pass is being driven with the expected inputs.
    task automatic check_hi_pass(input logic [63:0] a, input logic [63:0] b,
                                 input logic ci_exp, input string name);
        repeat (S) @(posedge clk);
        #1;
        n_cmp++;
        if (alu_in1 !== a[63:32] || alu_in2 !== b[63:32] || alu_ci !== ci_exp) begin
            n_bad++;
            $display("FAIL %s hi_pass in1=%h in2=%h ci=%0b required %h/%h/%0b",
                     name, alu_in1, alu_in2, alu_ci, a[63:32], b[63:32], ci_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; r3_rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_wide = 1'b1;
        cmd_a = '1; cmd_b = '1; cmd_ci = 1'b1; rsp_ready = 1'b0;
        r3_cmd_valid = 1'b0; r3_cmd_op = '0; r3_cmd_wide = 1'b0;
        r3_cmd_a = '0; r3_cmd_b = '0; r3_cmd_ci = 1'b0; r3_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 64'd0 ||
            rsp_co !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rsp ready=%0b valid=%0b data=%h co=%0b err=%0b required 1/0/0/0/0",
                     cmd_ready, rsp_valid, rsp_data, rsp_co, rsp_err);
        end
        n_cmp++;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_ci !== 1'b0 || alu_a !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_alu in1=%h in2=%h ci=%0b a=%0d required all 0",
                     alu_in1, alu_in2, alu_ci, alu_a);
        end
        cmd_valid = 1'b0;
        rst = 1'b0; r3_rst = 1'b0;
    endtask

    task automatic test_narrow_add();
        issue(3'd4, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        get_rsp(0, "narrow_add");
    endtask

    task automatic test_wide_add();
        issue(3'd4, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        check_hi_pass(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, "wide_add");
        get_rsp(0, "wide_add");
    endtask

    task automatic test_wide_xor();
        issue(3'd2, 1'b1, 64'hF0F0_F0F0_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check_hi_pass(64'hF0F0_F0F0_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "wide_xor");
        get_rsp(0, "wide_xor");
    endtask

    task automatic test_wide_shift_err();
        issue(3'd6, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h4, 1'b0);
        get_rsp(0, "wide_sll_err");
        issue(3'd5, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h8, 1'b0);
        get_rsp(0, "narrow_srl_after_err");
    endtask

    task automatic test_ops();
        for (int op = 0; op < 8; op++) begin
            issue(3'(op), 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            get_rsp(0, $sformatf("narrow_op%0d", op));
        end
        for (int op = 0; op < 5; op++) begin
            issue(3'(op), 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            get_rsp(0, $sformatf("wide_op%0d", op));
        end
        issue(3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        get_rsp(0, "wide_add_full_carry");
    endtask

    task automatic test_backpressure();
        issue(3'd1, 1'b1, 64'hA5A5_0000_1234_0000, 64'h0000_5A5A_0000_4321, 1'b0);
        get_rsp(5, "backpressure");
    endtask

    task automatic test_back_to_back();
        issue(3'd7, 1'b0, 64'h0, 64'h0, 1'b0);
        get_rsp(0, "b2b_rsv");
        issue(3'd3, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
        get_rsp(0, "b2b_not");
        issue(3'd4, 1'b0, 64'hFFFF_FFFF_7FFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1);
        get_rsp(1, "b2b_add_ci");
    endtask

    task automatic test_reset_in_hi();
        int n;
        @(negedge clk);
        r3_cmd_valid = 1'b1; r3_cmd_op = 3'd4; r3_cmd_wide = 1'b1;
        r3_cmd_a = 64'h1111_2222_FFFF_FFFF; r3_cmd_b = 64'h3333_4444_0000_0001; r3_cmd_ci = 1'b0;
        n = 0;
        while (!r3_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        r3_cmd_valid = 1'b0;
        repeat (S3) @(posedge clk);
        #1;
        n_cmp++;
        if (r3_alu_in1 !== 32'h1111_2222 || r3_alu_ci !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_hi in_hi in1=%h ci=%0b required 11112222/1", r3_alu_in1, r3_alu_ci);
        end
        @(negedge clk);
        r3_rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (r3_cmd_ready !== 1'b1 || r3_rsp_valid !== 1'b0 || r3_rsp_data !== 64'd0 ||
            r3_rsp_co !== 1'b0 || r3_rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_hi rsp ready=%0b valid=%0b data=%h co=%0b err=%0b required 1/0/0/0/0",
                     r3_cmd_ready, r3_rsp_valid, r3_rsp_data, r3_rsp_co, r3_rsp_err);
        end
        n_cmp++;
        if (r3_alu_in1 !== 32'd0 || r3_alu_in2 !== 32'd0 || r3_alu_ci !== 1'b0 || r3_alu_a !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_hi alu in1=%h in2=%h ci=%0b a=%0d required all 0",
                     r3_alu_in1, r3_alu_in2, r3_alu_ci, r3_alu_a);
        end
`ifdef ALU_ISSUE_CNT_EN
        n_cmp++;
        if (r3_op_count !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_hi op_count got=%0d required=0", r3_op_count);
        end
`endif
        r3_rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (r3_rsp_valid !== 1'b0) n++;
        end
        n_cmp++;
        if (n != 0) begin
            n_bad++;
            $display("FAIL rst_hi lost_rsp valid_cycles=%0d required=0", n);
        end
    endtask

`ifdef ALU_ISSUE_CNT_EN
    task automatic test_counters();
        @(negedge clk);
        n_cmp++;
        if (op_count !== 32'(n_rsp_hs)) begin
            n_bad++;
            $display("FAIL op_count got=%0d required=%0d", op_count, n_rsp_hs);
        end
        n_cmp++;
        if (err_count !== 16'(n_err_hs)) begin
            n_bad++;
            $display("FAIL err_count got=%0d required=%0d", err_count, n_err_hs);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_narrow_add();
        test_wide_add();
        test_wide_xor();
        test_wide_shift_err();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_in_hi();
`ifdef ALU_ISSUE_CNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential command front-end that drives the team's 32-bit gate-level ALU (operands In1/In2, carry CI, 3-bit opcode A; results FinalOut and CO).
- Accepts commands through a valid/ready handshake, registers the ALU inputs, and waits a programmable settle time before sampling the ALU outputs.
- Optionally chains two ALU passes to produce a 64-bit result, carrying CO from the low pass into the high pass.
- Returns results through a valid/ready response channel.

Parameters:
- SETTLE_CYCLES, 1: cycles ALU inputs are held stable before sampling; legal range 1..15.
- OP_W, 3: opcode width; fixed, matches the ALU decoder.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  3  0 AND, 1 OR, 2 XOR, 3 NOT(a), 4 ADD, 5 SRL, 6 SLL, 7 reserved
- cmd_wide  in  1  64-bit operation (two ALU passes)
- cmd_a  in  64  operand A (narrow uses [31:0])
- cmd_b  in  64  operand B (narrow uses [31:0])
- cmd_ci  in  1  carry-in for ADD
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_data  out  64  result
- rsp_co  out  1  final carry-out (ADD only, else 0)
- rsp_err  out  1  illegal wide request
- alu_in1  out  32  to ALU In1
- alu_in2  out  32  to ALU In2
- alu_ci  out  1  to ALU CI
- alu_a  out  3  to ALU opcode A
- alu_out  in  32  from ALU FinalOut
- alu_co  in  1  from ALU CO

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-high, rst.
- Reset:
  - FSM goes to IDLE; settle counter = 0.
  - cmd_ready = 1; rsp_valid = 0; rsp_data = 0; rsp_co = 0; rsp_err = 0.
  - alu_in1, alu_in2, alu_ci = 0; alu_a = 0.
  - All ALU-side outputs come from registers.
- FSM states: IDLE, LO, HI, RSP.
- IDLE:
  - cmd_ready = 1; the ALU is driven with zeros.
  - A handshake at edge T loads alu_in1 = a[31:0], alu_in2 = b[31:0], alu_a = op, alu_ci = (op==4) ? cmd_ci : 0.
  - The full command is latched; counter = SETTLE_CYCLES-1; next state LO.
- LO:
  - Holds the ALU inputs for SETTLE_CYCLES cycles.
  - At the edge where counter == 0, alu_out is captured into the low result and alu_co is captured.
  - Narrow command: next state RSP.
  - Wide command: alu_in1 = a[63:32], alu_in2 = b[63:32], alu_ci = (op==4) ? captured CO : 0; counter reloads; next state HI.
- HI:
  - Same settle timing as LO.
  - Captures the high result and alu_co; next state RSP.
- RSP:
  - rsp_valid = 1; the ALU inputs return to zero.
  - rsp_data, rsp_co and rsp_err are stable until rsp_valid && rsp_ready; then next state IDLE.
  - cmd_ready rises the cycle after the response handshake. There is no overlap of command and response.
- Latency (S = SETTLE_CYCLES, command accepted at edge T):
  - Narrow: rsp_valid is first high in cycle T+S+1.
  - Wide: rsp_valid is first high in cycle T+2S+1.
- Narrow result: rsp_data[63:32] = 0.
- Carry: rsp_co = last captured CO when op==4, else 0.
- Wide with op 5..7:
  - Runs the narrow path only; rsp_data[63:32] = 0; rsp_err = 1.
  - Shifts across 64 bits are unsupported.
- Op 7 passes through unchanged; rsp_data is whatever the ALU returns, and no error is raised for narrow use.
- cmd_* inputs are ignored outside IDLE.
- rst in any state aborts the operation immediately; the in-flight response is lost.

Optional Feature:
- Macro: ALU_ISSUE_CNT_EN.
- With the macro defined:
  - Adds output op_count[31:0], which increments on each response handshake and wraps 0xFFFFFFFF -> 0; reset value 0.
  - Adds output err_count[15:0], which increments on each handshake with rsp_err = 1 and saturates at 0xFFFF.
- Without the macro: neither port nor its logic exists.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3, OP_ADD=4, OP_SRL=5, OP_SLL=6, OP_RSV=7;
  - FSM state enum;
  - ALU_W=32.
- One sub-module: alu_settle_cnt (4-bit loadable down-counter with zero flag), used by LO and HI.

Test Plan:
1. Narrow ADD, a=0xFFFFFFFF, b=0x1, ci=0, S=1 -> rsp_valid at T+2; rsp_data=0x0000000000000000; rsp_co=1; rsp_err=0.
2. Wide ADD, a=0x00000000_FFFFFFFF, b=0x1, ci=0 -> high pass sees alu_ci=1; rsp_data=0x00000001_00000000; rsp_co=0; rsp_valid at T+3.
3. Wide XOR, a=0xF0F0F0F0_0F0F0F0F, b=0xFFFFFFFF_FFFFFFFF -> rsp_data=0x0F0F0F0F_F0F0F0F0; high-pass alu_ci=0.
4. Wide SLL (op 6) -> narrow execution only; rsp_err=1; rsp_data[63:32]=0; next command accepted normally.
5. Backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_data held; cmd_ready=0 throughout; cmd_ready=1 the cycle after the handshake.
6. With S=3, rst asserted during HI -> next cycle all outputs at reset values, FSM in IDLE; with ALU_ISSUE_CNT_EN defined, op_count stays 0.
